mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency memory between the CPU instruction-fetch requester (i-side, read only) and the load/store requester (d-side, read/write).
- Sits between the pc/flow_ctrl fetch path, the LW/SW execute path, and the cache array.
- Data accesses have fixed priority; a starvation counter forces an instruction grant after a bounded run of data grants.
- Exactly one memory transaction is in flight at a time.

---
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-port fixed-latency memory shared by i-fetch (read) and d-side (load/store).
// Latency: gnt/mem_en one cycle after the request is seen in IDLE, rvalid MEM_LAT+2 cycles after it.
// Backpressure: requests are only sampled in IDLE; requesters hold req until gnt, one access in flight.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LAT      = 1,
   parameter int MAX_D_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [3:0] LAT        = 4'(MEM_LAT);
   localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

   state_t            state, state_nxt;
   logic              owner_d;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [3:0]        lat_cnt;
   logic [3:0]        streak;
   logic              any_req;
   logic              pick_d;

   // Data side wins a contest until it has taken MAX_D_STREAK contested grants in a row.
   always_comb begin
      any_req   = i_req | d_req;
      pick_d    = d_req & (~i_req | (streak != MAX_STREAK));
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (lat_cnt == 4'd1) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      mem_en   = (state == ISSUE);
      mem_we   = mem_en & we_q;
      i_gnt    = mem_en & ~owner_d;
      d_gnt    = mem_en & owner_d;
      i_rvalid = (state == RESP) & ~owner_d;
      d_rvalid = (state == RESP) & owner_d;
      busy     = (state != IDLE);
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         owner_d <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         lat_cnt <= '0;
         streak  <= '0;
         i_rdata <= '0;
         d_rdata <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner_d <= pick_d;
                  we_q    <= pick_d & d_we;
                  addr_q  <= pick_d ? d_addr : i_addr;
                  wdata_q <= pick_d ? d_wdata : '0;
                  if (pick_d & i_req)
                     streak <= (streak == MAX_STREAK) ? streak : streak + 4'd1;
                  else
                     streak <= '0;
               end
            end
            ISSUE: lat_cnt <= LAT;
            WAIT: begin
               lat_cnt <= lat_cnt - 4'd1;
               // Counter at 1 marks cycle ISSUE+MEM_LAT, the only cycle mem_rdata is valid.
               if (lat_cnt == 4'd1) begin
                  if (owner_d) d_rdata <= we_q ? '0 : mem_rdata;
                  else         i_rdata <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) driven cycle by cycle,
// directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXS = 4;

   logic          clk;
   logic          rst;
   logic [DW-1:0] mem_rdata;

   logic          i_req    [2];
   logic [AW-1:0] i_addr   [2];
   logic          i_gnt    [2];
   logic          i_rvalid [2];
   logic [DW-1:0] i_rdata  [2];
   logic          d_req    [2];
   logic          d_we     [2];
   logic [AW-1:0] d_addr   [2];
   logic [DW-1:0] d_wdata  [2];
   logic          d_gnt    [2];
   logic          d_rvalid [2];
   logic [DW-1:0] d_rdata  [2];
   logic          mem_en   [2];
   logic          mem_we   [2];
   logic [AW-1:0] mem_addr [2];
   logic [DW-1:0] mem_wdata[2];
   logic          busy     [2];

   int cyc;
   int checks;
   int passes;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_D_STREAK(MAXS)) u_lat1 (
      .clk(clk), .rst(rst),
      .i_req(i_req[0]), .i_addr(i_addr[0]), .i_gnt(i_gnt[0]), .i_rvalid(i_rvalid[0]), .i_rdata(i_rdata[0]),
      .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
      .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .mem_rdata(mem_rdata), .busy(busy[0])
   );

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .MAX_D_STREAK(MAXS)) u_lat3 (
      .clk(clk), .rst(rst),
      .i_req(i_req[1]), .i_addr(i_addr[1]), .i_gnt(i_gnt[1]), .i_rvalid(i_rvalid[1]), .i_rdata(i_rdata[1]),
      .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
      .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .mem_rdata(mem_rdata), .busy(busy[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory read data is a distinct value per cycle, so the captured word identifies its cycle.
   function automatic logic [31:0] mdat(input int c);
      return 32'h5A00_0000 ^ (32'(c) * 32'h0001_0203);
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // {busy, mem_en, i_gnt, i_rvalid, d_gnt, d_rvalid}
   function automatic logic [5:0] pulses(input int k);
      return {busy[k], mem_en[k], i_gnt[k], i_rvalid[k], d_gnt[k], d_rvalid[k]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      mem_rdata = mdat(cyc);
   endtask

   task automatic idle_inputs();
      for (int k = 0; k < 2; k++) begin
         i_req[k]   = 1'b0;
         i_addr[k]  = '0;
         d_req[k]   = 1'b0;
         d_we[k]    = 1'b0;
         d_addr[k]  = '0;
         d_wdata[k] = '0;
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      i_req[0] = 1'b1;
      d_req[1] = 1'b1;
      step();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({pulses(k), mem_we[k], i_rdata[k], d_rdata[k], mem_addr[k], mem_wdata[k]} !== '0)
            $display("FAIL reset_outputs[%0d]: got pulses %b rdata %h/%h addr %h, required all 0",
                     k, pulses(k), i_rdata[k], d_rdata[k], mem_addr[k]);
         else passes++;
      end
      idle_inputs();
      rst = 1'b0;
      step();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (pulses(k) !== 6'b0)
            $display("FAIL reset_req_dominates[%0d]: got pulses %b, required 000000", k, pulses(k));
         else passes++;
      end
   endtask

   task automatic test_ifetch();
      logic [5:0] e;
      i_req[0]  = 1'b1;
      i_addr[0] = 32'h40;
      for (int n = 1; n <= 5; n++) begin
         step();
         if (n == 2) mem_rdata = 32'h0000_0013;
         e = 6'b0;
         if (n >= 1 && n <= 3) e[5] = 1'b1;
         if (n == 1) e[4:3] = 2'b11;
         if (n == 3) e[2] = 1'b1;
         checks++;
         if (pulses(0) !== e) $display("FAIL ifetch_pulses n=%0d: got %b required %b", n, pulses(0), e);
         else passes++;
         if (n == 1) begin
            checks++;
            if ({mem_we[0], mem_addr[0]} !== {1'b0, 32'h40})
               $display("FAIL ifetch_mem: got we=%b addr=%h required we=0 addr=00000040", mem_we[0], mem_addr[0]);
            else passes++;
            i_req[0] = 1'b0;
         end
         if (n == 3) begin
            checks++;
            if (i_rdata[0] !== 32'h13) $display("FAIL ifetch_rdata: got %h required 00000013", i_rdata[0]);
            else passes++;
         end
      end
   endtask

   task automatic test_contest();
      logic [5:0] e;
      int t, L;
      L = lat_of(0);
      t = cyc;
      i_req[0]  = 1'b1;
      i_addr[0] = 32'h44;
      d_req[0]  = 1'b1;
      d_we[0]   = 1'b0;
      d_addr[0] = 32'h100;
      for (int n = 1; n <= 2 * L + 7; n++) begin
         step();
         e = 6'b0;
         if (n >= 1 && n <= 2 + L) e[5] = 1'b1;
         if (n == 1) begin e[4] = 1'b1; e[1] = 1'b1; end
         if (n == 2 + L) e[0] = 1'b1;
         if (n >= 4 + L && n <= 5 + 2 * L) e[5] = 1'b1;
         if (n == 4 + L) begin e[4] = 1'b1; e[3] = 1'b1; end
         if (n == 5 + 2 * L) e[2] = 1'b1;
         checks++;
         if (pulses(0) !== e) $display("FAIL contest_pulses n=%0d: got %b required %b", n, pulses(0), e);
         else passes++;
         if (n == 1 || n == 4 + L) begin
            checks++;
            if (mem_addr[0] !== ((n == 1) ? 32'h100 : 32'h44))
               $display("FAIL contest_addr n=%0d: got %h", n, mem_addr[0]);
            else passes++;
         end
         if (n == 1) d_req[0] = 1'b0;
         if (n == 4 + L) i_req[0] = 1'b0;
         if (n == 2 + L) begin
            checks++;
            if (d_rdata[0] !== mdat(t + 1 + L)) $display("FAIL contest_d_rdata: got %h required %h", d_rdata[0], mdat(t + 1 + L));
            else passes++;
         end
         if (n == 5 + 2 * L) begin
            checks++;
            if (i_rdata[0] !== mdat(t + 4 + 2 * L)) $display("FAIL contest_i_rdata: got %h required %h", i_rdata[0], mdat(t + 4 + 2 * L));
            else passes++;
         end
      end
   endtask

   task automatic test_store();
      logic [5:0] e;
      d_req[0]   = 1'b1;
      d_we[0]    = 1'b1;
      d_addr[0]  = 32'h200;
      d_wdata[0] = 32'hDEAD_BEEF;
      for (int n = 1; n <= 5; n++) begin
         step();
         e = 6'b0;
         if (n <= 3) e[5] = 1'b1;
         if (n == 1) begin e[4] = 1'b1; e[1] = 1'b1; end
         if (n == 3) e[0] = 1'b1;
         checks++;
         if (pulses(0) !== e) $display("FAIL store_pulses n=%0d: got %b required %b", n, pulses(0), e);
         else passes++;
         if (n == 1) begin
            checks++;
            if ({mem_we[0], mem_addr[0], mem_wdata[0]} !== {1'b1, 32'h200, 32'hDEAD_BEEF})
               $display("FAIL store_mem: got we=%b addr=%h wdata=%h required 1/00000200/deadbeef",
                        mem_we[0], mem_addr[0], mem_wdata[0]);
            else passes++;
            d_req[0] = 1'b0;
            d_we[0]  = 1'b0;
         end
         if (n == 3) begin
            checks++;
            if (d_rdata[0] !== 32'h0) $display("FAIL store_rdata: got %h required 00000000", d_rdata[0]);
            else passes++;
         end
      end
   endtask

   task automatic test_starvation();
      logic got_d[$];
      int   gcyc[$];
      int   s, L;
      logic exp_d;
      L = lat_of(0);
      s = 0;
      i_req[0]  = 1'b1;
      i_addr[0] = 32'h1000;
      d_req[0]  = 1'b1;
      d_addr[0] = 32'h2000;
      for (int n = 0; n < 50; n++) begin
         step();
         if ((i_gnt[0] || d_gnt[0]) && got_d.size() < 10) begin
            got_d.push_back(d_gnt[0]);
            gcyc.push_back(cyc);
            checks++;
            if (mem_addr[0] !== (d_gnt[0] ? 32'h2000 : 32'h1000))
               $display("FAIL starve_addr: got %h for d_gnt=%b", mem_addr[0], d_gnt[0]);
            else passes++;
            if (got_d.size() == 10) begin
               i_req[0] = 1'b0;
               d_req[0] = 1'b0;
            end
         end
      end
      for (int j = 0; j < 10; j++) begin
         exp_d = (s != MAXS);
         s     = exp_d ? s + 1 : 0;
         checks++;
         if (j >= got_d.size()) $display("FAIL starve_order grant %0d: got none required %s", j, exp_d ? "d" : "i");
         else if (got_d[j] !== exp_d) $display("FAIL starve_order grant %0d: got d=%b required d=%b", j, got_d[j], exp_d);
         else passes++;
         if (j > 0 && j < gcyc.size()) begin
            checks++;
            if (gcyc[j] - gcyc[j-1] != L + 3)
               $display("FAIL starve_spacing grant %0d: got %0d cycles required %0d", j, gcyc[j] - gcyc[j-1], L + 3);
            else passes++;
         end
      end
   endtask

   task automatic test_latency();
      logic [5:0] e;
      int t;
      t = cyc;
      d_req[1]  = 1'b1;
      d_we[1]   = 1'b0;
      d_addr[1] = 32'h300;
      for (int n = 1; n <= 7; n++) begin
         step();
         e = 6'b0;
         if (n <= 5) e[5] = 1'b1;
         if (n == 1) begin e[4] = 1'b1; e[1] = 1'b1; d_req[1] = 1'b0; end
         if (n == 5) e[0] = 1'b1;
         checks++;
         if (pulses(1) !== e) $display("FAIL latency_pulses n=%0d: got %b required %b", n, pulses(1), e);
         else passes++;
         if (n == 5) begin
            checks++;
            if (d_rdata[1] !== mdat(t + 4)) $display("FAIL latency_rdata: got %h required %h", d_rdata[1], mdat(t + 4));
            else passes++;
         end
      end
   endtask

   task automatic test_reset_midop();
      logic [5:0] e;
      int t;
      d_req[1]  = 1'b1;
      d_addr[1] = 32'h304;
      for (int n = 1; n <= 7; n++) begin
         step();
         if (n == 1) d_req[1] = 1'b0;
         if (n >= 3) begin
            checks++;
            if (pulses(1) !== 6'b0) $display("FAIL midrst_quiet n=%0d: got %b required 000000", n, pulses(1));
            else passes++;
         end
         if (n == 3) begin
            checks++;
            if (d_rdata[1] !== 32'h0) $display("FAIL midrst_rdata: got %h required 00000000", d_rdata[1]);
            else passes++;
            rst = 1'b0;
         end
         if (n == 2) rst = 1'b1;
      end
      t = cyc;
      i_req[1]  = 1'b1;
      i_addr[1] = 32'h80;
      for (int n = 1; n <= 6; n++) begin
         step();
         e = 6'b0;
         if (n <= 5) e[5] = 1'b1;
         if (n == 1) begin e[4:3] = 2'b11; i_req[1] = 1'b0; end
         if (n == 5) e[2] = 1'b1;
         checks++;
         if (pulses(1) !== e) $display("FAIL midrst_fresh n=%0d: got %b required %b", n, pulses(1), e);
         else passes++;
         if (n == 5) begin
            checks++;
            if (i_rdata[1] !== mdat(t + 4)) $display("FAIL midrst_fresh_rdata: got %h required %h", i_rdata[1], mdat(t + 4));
            else passes++;
         end
      end
   endtask

   // Reference model: one transaction record; grant, response and next-arbitration cycles are plain arithmetic.
   task automatic test_random(input int k, input int ncyc);
      int          L, free_at, s, g_c, r_c;
      bit          act, own_d, t_we;
      logic [31:0] t_addr, t_wdata, t_rd, li, ld;
      logic [5:0]  e;
      L = lat_of(k);
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      free_at = cyc; s = 0; act = 1'b0; own_d = 1'b0; t_we = 1'b0;
      g_c = 0; r_c = 0; t_addr = '0; t_wdata = '0; t_rd = '0; li = '0; ld = '0;
      for (int n = 0; n < ncyc; n++) begin
         e = 6'b0;
         if (act && cyc >= g_c && cyc <= r_c) e[5] = 1'b1;
         if (act && cyc == g_c) begin e[4] = 1'b1; if (own_d) e[1] = 1'b1; else e[3] = 1'b1; end
         if (act && cyc == r_c) begin
            if (own_d) begin e[0] = 1'b1; ld = t_rd; end
            else       begin e[2] = 1'b1; li = t_rd; end
         end
         checks++;
         if (pulses(k) !== e) $display("FAIL rand%0d_pulses cyc=%0d: got %b required %b", k, cyc, pulses(k), e);
         else passes++;
         if (act && cyc == g_c) begin
            checks++;
            if ({mem_we[k], mem_addr[k]} !== {t_we, t_addr} || (t_we && mem_wdata[k] !== t_wdata))
               $display("FAIL rand%0d_mem cyc=%0d: got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                        k, cyc, mem_we[k], mem_addr[k], mem_wdata[k], t_we, t_addr, t_wdata);
            else passes++;
            if (own_d) d_req[k] = 1'b0;
            else       i_req[k] = 1'b0;
         end
         checks++;
         if ({i_rdata[k], d_rdata[k]} !== {li, ld})
            $display("FAIL rand%0d_rdata cyc=%0d: got %h/%h required %h/%h", k, cyc, i_rdata[k], d_rdata[k], li, ld);
         else passes++;
         if (act && cyc == r_c) act = 1'b0;
         if (!i_req[k] && $urandom_range(2) == 0) begin
            i_req[k]  = 1'b1;
            i_addr[k] = $urandom;
         end
         if (!d_req[k] && $urandom_range(2) == 0) begin
            d_req[k]   = 1'b1;
            d_we[k]    = 1'($urandom_range(1));
            d_addr[k]  = $urandom;
            d_wdata[k] = $urandom;
         end
         if (cyc >= free_at && (i_req[k] || d_req[k])) begin
            own_d   = d_req[k] && (!i_req[k] || s != MAXS);
            t_we    = own_d && d_we[k];
            t_addr  = own_d ? d_addr[k] : i_addr[k];
            t_wdata = d_wdata[k];
            t_rd    = t_we ? 32'h0 : mdat(cyc + 1 + L);
            if (own_d && i_req[k]) s = (s < MAXS) ? s + 1 : s;
            else                   s = 0;
            g_c     = cyc + 1;
            r_c     = cyc + 2 + L;
            free_at = cyc + 3 + L;
            act     = 1'b1;
         end
         step();
      end
      idle_inputs();
      repeat (L + 4) step();
   endtask

   initial begin
      cyc       = 0;
      checks    = 0;
      passes    = 0;
      rst       = 1'b1;
      mem_rdata = '0;
      idle_inputs();
      test_reset();
      test_ifetch();
      test_contest();
      test_store();
      test_starvation();
      test_latency();
      test_reset_midop();
      test_random(0, 300);
      test_random(1, 300);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
